// File: rtl/mbist_serial_ctrl_if.sv
// mbist_serial_ctrl_if: serial access port and BIST engine signals of mbist_serial_ctrl
interface mbist_serial_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ALGO_W = 2
);
  logic SEN;
  logic SDI;
  logic SDO;
  logic [NUM_CH-1:0] men;
  logic [NUM_CH-1:0] bist_go;
  logic [NUM_CH-1:0] bist_done;
  logic [ALGO_W-1:0] algo_sel;
  modport master(output SEN, SDI, bist_go, bist_done, input SDO, men, algo_sel);
  modport slave(input SEN, SDI, bist_go, bist_done, output SDO, men, algo_sel);
endinterface

// File: rtl/mbist_serial_ctrl.sv
// mbist_serial_ctrl: SEN/SDI instruction-then-data serial controller driving NUM_CH BIST engines
module mbist_serial_ctrl #(
  parameter int NUM_CH = 4,
  parameter int ALGO_W = 2,
  parameter int IR_WIDTH = 2
) (
  input logic SCK,
  input logic SRST,
  mbist_serial_ctrl_if.slave sif
);
  localparam int CMD_W = NUM_CH + ALGO_W;
  localparam int RES_W = 2 * NUM_CH;
  localparam int STAT_W = NUM_CH + 1;
  localparam int DR_MAX = CMD_W > RES_W ? (CMD_W > STAT_W ? CMD_W : STAT_W)
                                        : (RES_W > STAT_W ? RES_W : STAT_W);
  localparam int CNT_MAX = (IR_WIDTH > DR_MAX ? IR_WIDTH : DR_MAX) + 1;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [1:0] IDLE_IR = 2'd0, SHIFT_IR = 2'd1, IDLE_DR = 2'd2, SHIFT_DR = 2'd3;
  logic [1:0] state;
  logic [IR_WIDTH-1:0] ir, ir_sr;
  logic [DR_MAX-1:0] dr_sr, dr_shift, capture, lo_mask;
  logic [CNT_W-1:0] bit_cnt, len;
  logic [NUM_CH-1:0] fail_sticky, fail_set, fail_clr;
  logic frame_err, is_cmd, is_res, is_stat, ir_bad, dr_upd, dr_bad;
  assign is_cmd = ir == IR_WIDTH'(1);
  assign is_res = ir == IR_WIDTH'(2);
  assign is_stat = ir == IR_WIDTH'(3);
  assign len = is_cmd ? CNT_W'(CMD_W) : is_res ? CNT_W'(RES_W) : is_stat ? CNT_W'(STAT_W) : CNT_W'(1);
  assign ir_bad = state == SHIFT_IR && !sif.SEN && bit_cnt != CNT_W'(IR_WIDTH);
  assign dr_upd = state == SHIFT_DR && !sif.SEN && bit_cnt == len;
  assign dr_bad = state == SHIFT_DR && !sif.SEN && bit_cnt != len;
  assign fail_set = sif.men & sif.bist_done & ~sif.bist_go;
  assign fail_clr = dr_upd && is_cmd ? dr_sr[NUM_CH-1:0] & ~sif.men : '0;
  assign sif.SDO = state[1] & dr_sr[0];
  // SDI lands at bit len-1; bits at or above len are dropped
  assign lo_mask = (DR_MAX'(1) << (len - CNT_W'(1))) - DR_MAX'(1);
  assign dr_shift = ((dr_sr >> 1) & lo_mask) | (DR_MAX'(sif.SDI) << (len - CNT_W'(1)));
  always_comb begin
    capture = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      capture[2*k] = is_res & sif.bist_done[k];
      capture[2*k+1] = is_res & sif.bist_go[k];
    end
    if (is_cmd) capture[CMD_W-1:0] = {sif.algo_sel, sif.men};
    if (is_stat) capture[STAT_W-1:0] = {frame_err, fail_sticky};
  end
  always_ff @(posedge SCK) begin
    if (SRST) begin
      state <= IDLE_IR;
      ir <= '0;
      ir_sr <= '0;
      dr_sr <= '0;
      bit_cnt <= '0;
      sif.men <= '0;
      sif.algo_sel <= '0;
      fail_sticky <= '0;
      frame_err <= 1'b0;
    end else begin
      fail_sticky <= (fail_sticky & ~fail_clr) | fail_set;
      frame_err <= ir_bad | dr_bad | (frame_err & ~(dr_upd & is_stat));
      bit_cnt <= !sif.SEN ? bit_cnt : !state[0] ? CNT_W'(1)
               : bit_cnt == CNT_W'(CNT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
      if (sif.SEN) begin
        state <= state | 2'd1;
        if (state[1]) dr_sr <= dr_shift;
        else ir_sr <= {sif.SDI, ir_sr[IR_WIDTH-1:1]};
      end else begin
        if (state == SHIFT_IR) begin
          state <= IDLE_DR;
          ir <= ir_bad ? '0 : ir_sr;
        end
        if (state == SHIFT_DR) state <= IDLE_IR;
        if (state == IDLE_DR) dr_sr <= capture;
        if (dr_upd && is_cmd) begin
          sif.men <= dr_sr[NUM_CH-1:0];
          sif.algo_sel <= dr_sr[CMD_W-1:NUM_CH];
        end
      end
    end
  end
endmodule

// File: tb/tb_mbist_serial_ctrl.sv
// tb_mbist_serial_ctrl: directed and random frames checked against a frame-level model
module tb_mbist_serial_ctrl;
  localparam int N = 4, A = 2, IRW = 2;
  logic SCK = 1'b0;
  logic SRST = 1'b1;
  mbist_serial_ctrl_if #(.NUM_CH(N), .ALGO_W(A)) sif();
  mbist_serial_ctrl #(.NUM_CH(N), .ALGO_W(A), .IR_WIDTH(IRW)) dut(.SCK(SCK), .SRST(SRST), .sif(sif));
  always #5 SCK = ~SCK;
  int checks = 0, errors = 0;
  logic [N-1:0] men_m, fail_m;
  logic [A-1:0] algo_m;
  logic ferr_m;
  int ir_m;
  logic [31:0] rd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int dr_len();
    return ir_m == 1 ? N + A : ir_m == 2 ? 2 * N : ir_m == 3 ? N + 1 : 1;
  endfunction
  function automatic logic [31:0] cap_model();
    logic [31:0] v = '0;
    if (ir_m == 1) v = 32'({algo_m, men_m});
    else if (ir_m == 3) v = 32'({ferr_m, fail_m});
    else if (ir_m == 2)
      for (int k = 0; k < N; k++) begin
        v[2*k] = sif.bist_done[k];
        v[2*k+1] = sif.bist_go[k];
      end
    return v;
  endfunction
  // one clock: drive at negedge, model the sticky-fail rule at the edge
  task automatic step(input logic sen, input logic sdi, input logic [N-1:0] clr = '0);
    sif.SEN = sen;
    sif.SDI = sdi;
    @(posedge SCK);
    fail_m = (fail_m & ~clr) | (men_m & sif.bist_done & ~sif.bist_go);
    @(negedge SCK);
  endtask
  task automatic do_reset();
    SRST = 1'b1;
    sif.SEN = 1'b0;
    sif.SDI = 1'b0;
    repeat (2) @(negedge SCK);
    SRST = 1'b0;
    men_m = '0; algo_m = '0; fail_m = '0; ferr_m = 1'b0; ir_m = 0;
    check("rst_men", 32'(sif.men), 32'd0);
    check("rst_algo", 32'(sif.algo_sel), 32'd0);
    check("rst_sdo", 32'(sif.SDO), 32'd0);
  endtask
  task automatic ir_frame(input int code, input int nbits);
    for (int i = 0; i < nbits; i++) step(1'b1, 1'(code >> i));
    step(1'b0, 1'b0);
    if (nbits == IRW) ir_m = code & 3;
    else begin
      ir_m = 0;
      ferr_m = 1'b1;
    end
  endtask
  task automatic dr_frame(input string tag, input int n, input logic [31:0] wdata);
    int l;
    logic [31:0] exp, mask;
    logic [N-1:0] clr;
    l = dr_len();
    clr = '0;
    exp = cap_model();
    step(1'b0, 1'b0);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 32) rd[i] = sif.SDO;
      step(1'b1, wdata[i % 32]);
    end
    if (ir_m == 1 && n == l) clr = wdata[N-1:0] & ~men_m;
    step(1'b0, 1'b0, clr);
    if (n != l) ferr_m = 1'b1;
    else if (ir_m == 1) begin
      men_m = wdata[N-1:0];
      algo_m = wdata[N+A-1:N];
    end else if (ir_m == 3) ferr_m = 1'b0;
    mask = (32'd1 << (n < l ? n : l)) - 32'd1;
    check({tag, "_sdo"}, rd & mask, exp & mask);
    check({tag, "_men"}, 32'(sif.men), 32'(men_m));
    check({tag, "_algo"}, 32'(sif.algo_sel), 32'(algo_m));
    check({tag, "_idle_sdo"}, 32'(sif.SDO), 32'd0);
  endtask
  initial begin
    int code, nb, l, r, n;
    sif.SEN = 1'b0; sif.SDI = 1'b0; sif.bist_go = '0; sif.bist_done = '0;
    @(negedge SCK);
    do_reset();
    ir_frame(3, 2);
    dr_frame("stat0", N + 1, 32'd0);
    ir_frame(1, 2);
    repeat (5) step(1'b0, 1'b0);
    dr_frame("cmd", N + A, 32'b100101);
    check("cmd_men_k", 32'(sif.men), 32'b0101);
    check("cmd_algo_k", 32'(sif.algo_sel), 32'b10);
    sif.bist_done = 4'b1111; sif.bist_go = 4'b1011;
    ir_frame(2, 2);
    repeat (5) step(1'b0, 1'b0);
    dr_frame("res", 2 * N, 32'd0);
    check("res_seq_k", 32'(rd[7:0]), 32'b11011111);
    ir_frame(3, 2);
    dr_frame("stat_fail", N + 1, 32'd0);
    check("stat_fail_k", 32'(rd[4:0]), 32'b00100);
    sif.bist_done = '0;
    ir_frame(1, 2);
    dr_frame("cmd_off", N + A, 32'b100001);
    ir_frame(1, 2);
    dr_frame("cmd_on", N + A, 32'b100101);
    ir_frame(3, 2);
    dr_frame("stat_clr", N + 1, 32'd0);
    check("stat_clr_k", 32'(rd[4:0]), 32'd0);
    ir_frame(1, 2);
    dr_frame("short", 4, 32'hf);
    check("short_men_k", 32'(sif.men), 32'b0101);
    ir_frame(3, 2);
    dr_frame("ferr1", N + 1, 32'd0);
    check("ferr1_k", 32'(rd[4]), 32'd1);
    ir_frame(3, 2);
    dr_frame("ferr2", N + 1, 32'd0);
    check("ferr2_k", 32'(rd[4]), 32'd0);
    ir_frame(1, 2);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    do_reset();
    ir_frame(0, 2);
    dr_frame("byp", 1, 32'd1);
    check("byp_k", 32'(rd[0]), 32'd0);
    ir_frame(3, 2);
    dr_frame("stat_rst", N + 1, 32'd0);
    for (int it = 0; it < 300; it++) begin
      sif.bist_go = N'($urandom);
      sif.bist_done = N'($urandom);
      code = $urandom_range(0, 3);
      nb = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) == 1 ? 1 : 3) : IRW;
      ir_frame(code, nb);
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0);
      l = dr_len();
      r = $urandom_range(0, 9);
      n = r == 0 ? $urandom_range(1, 20) : r == 1 ? (l > 1 ? l - 1 : 2) : l;
      dr_frame("rnd", n, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
